// File: rtl/nvram_upload_pkg.sv
// nvram_upload_pkg: shared types and default sizing for the NVRAM upload path.
//   state_e         - upload controller states
//   DEF_ADDR_W      - default core RAM byte-address width
//   DEF_FIFO_DEPTH  - default staging FIFO depth (power of two, >= 4)
package nvram_upload_pkg;

   localparam int DEF_ADDR_W     = 12;
   localparam int DEF_FIFO_DEPTH = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WAIT,
      ST_DRAIN,
      ST_DONE
   } state_e;

endpackage

// File: rtl/nvram_upload_if.sv
// nvram_upload_if: host (data_io) and core-RAM signals of the NVRAM upload path.
//   host side : ioctl_upload, ioctl_rd, ioctl_din, start_addr, length
//   RAM side  : vblank, ram_addr, ram_rd, ram_q
//   master    : the host / RAM environment
//   slave     : the nvram_upload controller
interface nvram_upload_if
   import nvram_upload_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              ioctl_upload;
   logic              ioctl_rd;
   logic [7:0]        ioctl_din;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   length;
   logic              vblank;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_rd;
   logic [7:0]        ram_q;

   modport master (
      output ioctl_upload, ioctl_rd, start_addr, length, vblank, ram_q,
      input  ioctl_din, ram_addr, ram_rd
   );

   modport slave (
      input  ioctl_upload, ioctl_rd, start_addr, length, vblank, ram_q,
      output ioctl_din, ram_addr, ram_rd
   );

endinterface

// File: rtl/nvram_upload_fifo.sv
// upload_fifo: byte FIFO staging RAM data for the host.
//   clk_sys, reset_n - clock, async active-low reset
//   push, push_data  - write one byte (ignored when full without a pop)
//   pop              - drop the head entry (ignored when empty)
//   flush            - empty the FIFO; wins over push/pop
//   count            - current number of entries
//   head             - registered head byte, 8'hFF while empty
module upload_fifo
   import nvram_upload_pkg::*;
#(
   parameter  int DEPTH = DEF_FIFO_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic [7:0]    head
);

   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [CW-1:0] CNT_ONE  = 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    head_q, head_d;
   logic          do_push, do_pop, wr_en;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != FULL_CNT) || do_pop);
      wr_en    = do_push && !flush;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
      // The new head may be the byte being written this very cycle
      // (push into empty, or push+pop with a single entry left).
      if (count_d == '0)
         head_d = 8'hFF;
      else if (wr_en && (rd_ptr_d == wr_ptr_q))
         head_d = push_data;
      else
         head_d = mem_q[rd_ptr_d];
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= 8'hFF;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data;
   end

   assign count = count_q;
   assign head  = head_q;

endmodule

// File: rtl/nvram_upload.sv
// nvram_upload: streams a window of core RAM to the host during an upload
// session, reading RAM only while vblank is high and staging bytes in a FIFO.
//   clk_sys, reset_n - clock, async active-low reset
//   bus (slave)      - host handshake and RAM read port
//   busy             - session fetching or draining
//   done             - all bytes handed to the host
//   underrun         - sticky: host read while FIFO empty and bytes still owed
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no session; waiting for ioctl_upload rising edge
// ST_FILL  | issuing RAM reads while vblank high and FIFO has room
// ST_WAIT  | vblank low or FIFO reservation full; reads paused
// ST_DRAIN | all bytes fetched; host emptying the FIFO
// ST_DONE  | FIFO empty; waiting for ioctl_upload to fall
module nvram_upload
   import nvram_upload_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic           clk_sys,
   input  logic           reset_n,
   nvram_upload_if.slave  bus,
   output logic           busy,
   output logic           done,
   output logic           underrun
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]       RESV_MAX = (CW + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W:0]   REM_ONE  = 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              ram_rd_q, ram_rd_d;
   logic              rd_dly_q, rd_dly_d;
   logic              upload_q;
   logic              underrun_q, underrun_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              fifo_push, fifo_flush;
   logic [CW-1:0]     fifo_count;
   logic [7:0]        fifo_head;

   logic              upl_rise, upl_fall, fill_or_wait, no_flight, resv_full, owed;
   logic [CW:0]       resv;

   upload_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (bus.ram_q),
      .pop       (bus.ioctl_rd),
      .flush     (fifo_flush),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   always_comb begin
      upl_rise     = bus.ioctl_upload && !upload_q;
      upl_fall     = !bus.ioctl_upload && upload_q;
      fill_or_wait = (state_q == ST_FILL) || (state_q == ST_WAIT);
      // ram_rd_q: read on the bus now; rd_dly_q: its data is being pushed now.
      no_flight    = !ram_rd_q && !rd_dly_q;
      resv         = {1'b0, fifo_count} + (CW + 1)'(ram_rd_q) + (CW + 1)'(rd_dly_q);
      resv_full    = (resv >= RESV_MAX);
      owed         = (remaining_q != '0) || !no_flight;

      state_d      = state_q;
      ptr_d        = ptr_q;
      ram_addr_d   = ram_addr_q;
      remaining_d  = remaining_q;
      ram_rd_d     = 1'b0;
      rd_dly_d     = ram_rd_q;
      underrun_d   = underrun_q;
      fifo_push    = rd_dly_q && fill_or_wait;
      fifo_flush   = 1'b0;

      if ((state_q != ST_IDLE) && upl_fall) begin
         state_d    = ST_IDLE;
         fifo_flush = 1'b1;
         fifo_push  = 1'b0;
         rd_dly_d   = 1'b0;
      end else begin
         if (fill_or_wait && owed && bus.ioctl_rd && (fifo_count == '0))
            underrun_d = 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (upl_rise) begin
                  ptr_d       = bus.start_addr;
                  remaining_d = bus.length;
                  fifo_flush  = 1'b1;
                  underrun_d  = 1'b0;
                  state_d     = (bus.length == '0) ? ST_DONE : ST_FILL;
               end
            end
            ST_FILL: begin
               if ((remaining_q == '0) && no_flight) begin
                  state_d = ST_DRAIN;
               end else if (!bus.vblank || resv_full) begin
                  state_d = ST_WAIT;
               end else if (remaining_q != '0) begin
                  ram_rd_d    = 1'b1;
                  ram_addr_d  = ptr_q;
                  ptr_d       = ptr_q + PTR_ONE;
                  remaining_d = remaining_q - REM_ONE;
               end
            end
            ST_WAIT: begin
               if ((remaining_q == '0) && no_flight)
                  state_d = ST_DRAIN;
               else if (bus.vblank && !resv_full)
                  state_d = ST_FILL;
            end
            ST_DRAIN: begin
               if (fifo_count == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_FILL) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         ram_addr_q  <= '0;
         remaining_q <= '0;
         ram_rd_q    <= 1'b0;
         rd_dly_q    <= 1'b0;
         // Reset as "high" so an ioctl_upload already high when reset lifts
         // is not mistaken for a new session start.
         upload_q    <= 1'b1;
         underrun_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         ram_addr_q  <= ram_addr_d;
         remaining_q <= remaining_d;
         ram_rd_q    <= ram_rd_d;
         rd_dly_q    <= rd_dly_d;
         upload_q    <= bus.ioctl_upload;
         underrun_q  <= underrun_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.ioctl_din = fifo_head;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_rd    = ram_rd_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign underrun      = underrun_q;

endmodule

// File: tb/tb_nvram_upload.sv
module tb_nvram_upload;

   localparam int AW = 12;

   logic clk_sys = 1'b0;
   logic reset_n = 1'b1;
   logic busy, done, underrun;
   int   total = 0;
   int   bad   = 0;

   nvram_upload_if #(.ADDR_W(AW)) u_if ();

   nvram_upload #(.ADDR_W(AW), .FIFO_DEPTH(8)) dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .bus      (u_if),
      .busy     (busy),
      .done     (done),
      .underrun (underrun)
   );

   always #5 clk_sys = ~clk_sys;

   // RAM model: data valid the cycle after ram_rd; logs every read address.
   logic [7:0]    mem [4096];
   logic [7:0]    ram_q_r = 8'h00;
   logic [AW-1:0] addr_log [256];
   int            rd_cnt = 0;

   always @(posedge clk_sys) begin
      if (u_if.ram_rd) begin
         ram_q_r <= mem[u_if.ram_addr];
         addr_log[rd_cnt[7:0]] <= u_if.ram_addr;
         rd_cnt <= rd_cnt + 1;
      end
   end
   assign u_if.ram_q = ram_q_r;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic start_session(input logic [AW-1:0] sa, input logic [AW:0] len);
      u_if.start_addr   = sa;
      u_if.length       = len;
      u_if.ioctl_upload = 1'b1;
      @(negedge clk_sys);
   endtask

   task automatic end_session();
      u_if.ioctl_upload = 1'b0;
      cyc(2);
   endtask

   task automatic pop();
      u_if.ioctl_rd = 1'b1;
      @(negedge clk_sys);
      u_if.ioctl_rd = 1'b0;
   endtask

   task automatic test_reset();
      #1 reset_n = 1'b0;
      #2;
      total++; if (u_if.ioctl_din !== 8'hFF) begin bad++; $display("FAIL reset_din: got %h want ff", u_if.ioctl_din); end
      total++; if (u_if.ram_rd !== 1'b0) begin bad++; $display("FAIL reset_ram_rd: got %b want 0", u_if.ram_rd); end
      total++; if (u_if.ram_addr !== 12'h000) begin bad++; $display("FAIL reset_ram_addr: got %h want 000", u_if.ram_addr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
   endtask

   task automatic test_basic();
      logic [7:0] exp_b [4];
      int base;
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
      base = rd_cnt;
      u_if.vblank = 1'b1;
      start_session(12'h100, 13'd4);
      cyc(10);
      for (int k = 0; k < 4; k++) begin
         total++; if (u_if.ioctl_din !== exp_b[k]) begin bad++; $display("FAIL basic_din[%0d]: got %h want %h", k, u_if.ioctl_din, exp_b[k]); end
         pop();
         cyc(2);
      end
      total++; if (u_if.ioctl_din !== 8'hFF) begin bad++; $display("FAIL basic_din_empty: got %h want ff", u_if.ioctl_din); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done: got %b want 1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", busy); end
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL basic_underrun: got %b want 0", underrun); end
      total++; if (rd_cnt - base !== 4) begin bad++; $display("FAIL basic_rd_count: got %0d want 4", rd_cnt - base); end
      u_if.ioctl_upload = 1'b0;
      cyc(1);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_clear: got %b want 0", done); end
      cyc(1);
   endtask

   task automatic test_backpressure();
      int base;
      base = rd_cnt;
      u_if.vblank = 1'b1;
      start_session(12'h200, 13'd20);
      cyc(30);
      total++; if (rd_cnt - base !== 8) begin bad++; $display("FAIL bp_stall_count: got %0d want 8", rd_cnt - base); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b want 1", busy); end
      total++; if (u_if.ioctl_din !== mem[12'h200]) begin bad++; $display("FAIL bp_head0: got %h want %h", u_if.ioctl_din, mem[12'h200]); end
      pop();
      cyc(10);
      total++; if (rd_cnt - base !== 9) begin bad++; $display("FAIL bp_after_pop1: got %0d want 9", rd_cnt - base); end
      total++; if (u_if.ioctl_din !== mem[12'h201]) begin bad++; $display("FAIL bp_head1: got %h want %h", u_if.ioctl_din, mem[12'h201]); end
      pop();
      cyc(10);
      total++; if (rd_cnt - base !== 10) begin bad++; $display("FAIL bp_after_pop2: got %0d want 10", rd_cnt - base); end
      end_session();
      total++; if (u_if.ioctl_din !== 8'hFF) begin bad++; $display("FAIL bp_abort_din: got %h want ff", u_if.ioctl_din); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_abort_busy: got %b want 0", busy); end
   endtask

   task automatic test_vblank();
      int base;
      base = rd_cnt;
      u_if.vblank = 1'b1;
      start_session(12'h300, 13'd6);
      for (int i = 0; i < 20; i++) begin
         if (u_if.ram_rd) break;
         @(negedge clk_sys);
      end
      total++; if (u_if.ram_rd !== 1'b1) begin bad++; $display("FAIL vb_first_rd: ram_rd=%b want 1 within 20 cycles", u_if.ram_rd); end
      u_if.vblank = 1'b0;
      cyc(8);
      total++; if (rd_cnt - base !== 1) begin bad++; $display("FAIL vb_paused_count: got %0d want 1", rd_cnt - base); end
      total++; if (u_if.ioctl_din !== mem[12'h300]) begin bad++; $display("FAIL vb_inflight_push: got %h want %h", u_if.ioctl_din, mem[12'h300]); end
      u_if.vblank = 1'b1;
      cyc(20);
      total++; if (rd_cnt - base !== 6) begin bad++; $display("FAIL vb_resume_count: got %0d want 6", rd_cnt - base); end
      for (int k = 0; k < 6; k++) begin
         total++; if (u_if.ioctl_din !== mem[12'h300 + k]) begin bad++; $display("FAIL vb_order[%0d]: got %h want %h", k, u_if.ioctl_din, mem[12'h300 + k]); end
         pop();
      end
      cyc(3);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL vb_done: got %b want 1", done); end
      end_session();
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_a [4];
      int base;
      exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      base = rd_cnt;
      u_if.vblank = 1'b1;
      start_session(12'hFFE, 13'd4);
      cyc(12);
      total++; if (rd_cnt - base !== 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", rd_cnt - base); end
      for (int k = 0; k < 4; k++) begin
         total++; if (addr_log[8'(base + k)] !== exp_a[k]) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, addr_log[8'(base + k)], exp_a[k]); end
      end
      total++; if (u_if.ioctl_din !== mem[12'hFFE]) begin bad++; $display("FAIL wrap_head: got %h want %h", u_if.ioctl_din, mem[12'hFFE]); end
      end_session();
   endtask

   task automatic test_underrun();
      u_if.vblank = 1'b0;
      start_session(12'h400, 13'd4);
      cyc(2);
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_before: got %b want 0", underrun); end
      pop();
      total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set: got %b want 1", underrun); end
      total++; if (u_if.ioctl_din !== 8'hFF) begin bad++; $display("FAIL ur_din: got %h want ff", u_if.ioctl_din); end
      u_if.vblank = 1'b1;
      cyc(12);
      total++; if (underrun !== 1'b1) begin bad++; $display("FAIL ur_sticky: got %b want 1", underrun); end
      total++; if (u_if.ioctl_din !== mem[12'h400]) begin bad++; $display("FAIL ur_no_pop: got %h want %h", u_if.ioctl_din, mem[12'h400]); end
      end_session();
      start_session(12'h000, 13'd0);
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_new_session: got %b want 0", underrun); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL len0_done: got %b want 1", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL len0_busy: got %b want 0", busy); end
      pop();
      total++; if (underrun !== 1'b0) begin bad++; $display("FAIL ur_ignored_in_done: got %b want 0", underrun); end
      end_session();
   endtask

   task automatic test_abort_reset();
      int snap;
      u_if.vblank = 1'b1;
      start_session(12'h500, 13'd10);
      cyc(4);
      total++; if (u_if.ram_rd !== 1'b1) begin bad++; $display("FAIL ab_in_flight: ram_rd=%b want 1", u_if.ram_rd); end
      total++; if (u_if.ioctl_din !== mem[12'h500]) begin bad++; $display("FAIL ab_head: got %h want %h", u_if.ioctl_din, mem[12'h500]); end
      u_if.ioctl_upload = 1'b0;
      @(negedge clk_sys);
      snap = rd_cnt;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy: got %b want 0", busy); end
      total++; if (u_if.ram_rd !== 1'b0) begin bad++; $display("FAIL ab_ram_rd: got %b want 0", u_if.ram_rd); end
      total++; if (u_if.ioctl_din !== 8'hFF) begin bad++; $display("FAIL ab_flush: got %h want ff", u_if.ioctl_din); end
      cyc(3);
      total++; if (u_if.ioctl_din !== 8'hFF) begin bad++; $display("FAIL ab_no_push: got %h want ff", u_if.ioctl_din); end
      total++; if (rd_cnt !== snap) begin bad++; $display("FAIL ab_no_reads: got %0d want %0d", rd_cnt, snap); end

      start_session(12'h600, 13'd3);
      cyc(12);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
      total++; if (u_if.ioctl_din !== mem[12'h600]) begin bad++; $display("FAIL rst_pre_head: got %h want %h", u_if.ioctl_din, mem[12'h600]); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (u_if.ioctl_din !== 8'hFF) begin bad++; $display("FAIL rst_mid_din: got %h want ff", u_if.ioctl_din); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
      total++; if (u_if.ram_addr !== 12'h000) begin bad++; $display("FAIL rst_mid_addr: got %h want 000", u_if.ram_addr); end
      total++; if (u_if.ram_rd !== 1'b0) begin bad++; $display("FAIL rst_mid_rd: got %b want 0", u_if.ram_rd); end
      @(negedge clk_sys);
      reset_n = 1'b1;
      cyc(4);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_need_edge: busy=%b want 0", busy); end
      end_session();
      start_session(12'h600, 13'd3);
      cyc(12);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_fresh_busy: got %b want 1", busy); end
      total++; if (u_if.ioctl_din !== mem[12'h600]) begin bad++; $display("FAIL rst_fresh_head: got %h want %h", u_if.ioctl_din, mem[12'h600]); end
      end_session();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'((i * 7 + 3) & 255);
      mem[12'h100] = 8'h11;
      mem[12'h101] = 8'h22;
      mem[12'h102] = 8'h33;
      mem[12'h103] = 8'h44;
      u_if.ioctl_upload = 1'b0;
      u_if.ioctl_rd     = 1'b0;
      u_if.start_addr   = '0;
      u_if.length       = '0;
      u_if.vblank       = 1'b1;

      test_reset();
      test_basic();
      test_backpressure();
      test_vblank();
      test_wrap();
      test_underrun();
      test_abort_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
